// File: rtl/ram_scan_display.sv
// Single-port RAM that clears itself after reset. It is accessed either through
// debounced-by-synchroniser buttons or by a ticked auto-scan, and drives one hex 7-segment digit.
module ram_scan_display #(
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 4,
  parameter int CLK_HZ    = 10000000,
  parameter int TICK_HZ   = 2,
  parameter int READ_MODE = 0
) (
  input  logic              clk_in,
  input  logic              rst_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              wren_i,
  input  logic              rden_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              tick_o,
  output logic [6:0]        seg_o
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_q;
  logic [1:0]        sync1_q, sync2_q, prev_q;
  logic [1:0]        req;
  logic              wr_req, rd_req;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [6:0]        seg_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rword;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Bit 0 is the write button, bit 1 the read button; one request per rising level.
  assign req    = sync2_q & ~prev_q;
  assign wr_req = req[0];
  assign rd_req = req[1];

  assign cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk_in) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  assign ram_rword = mem[ram_addr];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    addr_d    = addr_q;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_i;
    ram_wdata = data_i;
    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = ptr_q;
        ram_wdata = '0;
        ptr_d     = ptr_q + ADDR_W'(1);
        busy_d    = 1'b1;
        if (ptr_q == LAST_ADDR) begin
          busy_d  = 1'b0;
          state_d = mode_i ? ST_SCAN : ST_MANUAL;
        end
      end
      ST_MANUAL: begin
        ram_we = wr_req;
        if (rd_req) begin
          // A simultaneous read and write share addr_i; READ_MODE picks old or new word.
          data_d  = (READ_MODE != 0 && wr_req) ? data_i : ram_rword;
          addr_d  = addr_i;
          valid_d = 1'b1;
        end
        if (mode_i) begin
          state_d = ST_SCAN;
          ptr_d   = '0;
        end
      end
      ST_SCAN: begin
        ram_addr = ptr_q;
        if (!mode_i) begin
          state_d = ST_MANUAL;
        end else if (tick_q) begin
          data_d  = ram_rword;
          addr_d  = ptr_q;
          valid_d = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
      seg_q   <= 7'b1000000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tick_q  <= (cnt_d == CNT_LAST);
      sync1_q <= {rden_i, wren_i};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      seg_q   <= hex_to_seg(data_q[3:0]);
    end
  end

  assign data_o  = data_q;
  assign addr_o  = addr_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign tick_o  = tick_q;
  assign seg_o   = seg_q;

endmodule

// File: tb/tb_ram_scan_display.sv
// Directed + randomized bench for ram_scan_display; two instances cover both READ_MODE settings.
module tb_ram_scan_display;

  localparam int DIV = 4;

  logic       clk_in = 1'b0;
  logic       rst_i, mode_i, wren_i, rden_i;
  logic [3:0] addr_i, data_i;
  logic [3:0] data0, data1, addr0, addr1;
  logic       valid0, valid1, busy0, busy1, tick0, tick1;
  logic [6:0] seg0, seg1;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   tick_chk_en = 0;
  logic last_tick = 1'b0;
  logic [3:0] mem_m [16];
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  ram_scan_display #(.DATA_W(4), .ADDR_W(4), .CLK_HZ(8), .TICK_HZ(2), .READ_MODE(0)) dut0 (
    .clk_in(clk_in), .rst_i(rst_i), .mode_i(mode_i), .addr_i(addr_i), .data_i(data_i),
    .wren_i(wren_i), .rden_i(rden_i), .data_o(data0), .addr_o(addr0), .valid_o(valid0),
    .busy_o(busy0), .tick_o(tick0), .seg_o(seg0));

  ram_scan_display #(.DATA_W(4), .ADDR_W(4), .CLK_HZ(8), .TICK_HZ(2), .READ_MODE(1)) dut1 (
    .clk_in(clk_in), .rst_i(rst_i), .mode_i(mode_i), .addr_i(addr_i), .data_i(data_i),
    .wren_i(wren_i), .rden_i(rden_i), .data_o(data1), .addr_o(addr1), .valid_o(valid1),
    .busy_o(busy1), .tick_o(tick1), .seg_o(seg1));

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the prescaler phase is known from the cycle count since reset release.
  task automatic clk_step();
    last_tick = tick0;
    @(posedge clk_in);
    #1;
    cyc++;
    if (tick_chk_en) begin
      chk("tick0", 32'(tick0), 32'((cyc % DIV) == (DIV - 1)));
      chk("tick1", 32'(tick1), 32'((cyc % DIV) == (DIV - 1)));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"},  32'(data0),  32'h0);
    chk({tag, "_addr"},  32'(addr0),  32'h0);
    chk({tag, "_valid"}, 32'(valid0), 32'h0);
    chk({tag, "_tick"},  32'(tick0),  32'h0);
    chk({tag, "_busy"},  32'(busy0),  32'h1);
    chk({tag, "_seg"},   32'(seg0),   32'h40);
    chk({tag, "_data1"}, 32'(data1),  32'h0);
  endtask

  task automatic release_and_count_busy(input string tag, input logic pulse_wr);
    int n;
    addr_i = 4'h0;
    data_i = 4'hF;
    wren_i = pulse_wr;
    rst_i = 1'b1;
    cyc = 0;
    tick_chk_en = 1;
    n = 0;
    while (busy0 && n < 40) begin
      clk_step();
      n++;
      if (n == 4) wren_i = 1'b0;
    end
    chk({tag, "_busy_len"}, 32'(n), 32'd16);
    chk({tag, "_busy1"}, 32'(busy1), 32'h0);
    for (int i = 0; i < 16; i++) mem_m[i] = 4'h0;
    $display("clear %s: busy for %0d cycles", tag, n);
  endtask

  // Scan n words from address 0; a write pulse may be injected while scanning.
  task automatic scan_check(input int n, input int pulse_at);
    int  w;
    int  a;
    mode_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == pulse_at) wren_i = 1'b1;
      if (i == pulse_at + 2) wren_i = 1'b0;
      w = 0;
      clk_step();
      while (!valid0 && w < 3 * DIV) begin
        clk_step();
        w++;
      end
      chk("scan_valid", 32'(valid0), 32'h1);
      a = i % 16;
      chk("scan_tick_before", 32'(last_tick), 32'h1);
      chk("scan_addr0", 32'(addr0), 32'(a));
      chk("scan_data0", 32'(data0), 32'(mem_m[a]));
      chk("scan_valid1", 32'(valid1), 32'h1);
      chk("scan_data1", 32'(data1), 32'(mem_m[a]));
      $display("scan addr=%0h data=%0h", addr0, data0);
      clk_step();
      chk("scan_pulse_len", 32'(valid0), 32'h0);
      chk("scan_seg", 32'(seg0), 32'(seg_tab[mem_m[a]]));
    end
    wren_i = 1'b0;
    mode_i = 1'b0;
    repeat (2) clk_step();
  endtask

  task automatic man_op(input logic we, input logic re, input logic [3:0] a, input logic [3:0] d);
    logic [3:0] exp0, exp1;
    addr_i = a;
    data_i = d;
    repeat (3) clk_step();
    exp0 = mem_m[a];
    exp1 = we ? d : mem_m[a];
    wren_i = we;
    rden_i = re;
    clk_step();
    clk_step();
    if (re) chk("op_early_valid", 32'(valid0), 32'h0);
    clk_step();
    if (re) begin
      chk("op_valid0", 32'(valid0), 32'h1);
      chk("op_data0",  32'(data0),  32'(exp0));
      chk("op_addr0",  32'(addr0),  32'(a));
      chk("op_valid1", 32'(valid1), 32'h1);
      chk("op_data1",  32'(data1),  32'(exp1));
    end
    if (we) mem_m[a] = d;
    clk_step();
    if (re) begin
      chk("op_valid_len", 32'(valid0), 32'h0);
      chk("op_seg0", 32'(seg0), 32'(seg_tab[exp0]));
      chk("op_seg1", 32'(seg1), 32'(seg_tab[exp1]));
    end
    wren_i = 1'b0;
    rden_i = 1'b0;
    repeat (3) clk_step();
    $display("op we=%0b re=%0b addr=%0h wdata=%0h rdata0=%0h rdata1=%0h", we, re, a, d, data0, data1);
  endtask

  initial begin
    logic [3:0] a, d, d2;
    int kind;
    rst_i = 1'b0;
    mode_i = 1'b0;
    addr_i = 4'h0;
    data_i = 4'h0;
    wren_i = 1'b0;
    rden_i = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");

    // Clear after reset, with a write pulse that must be ignored.
    release_and_count_busy("clear1", 1'b1);
    scan_check(16, -10);

    man_op(1'b1, 1'b0, 4'h3, 4'hA);
    man_op(1'b0, 1'b1, 4'h3, 4'h0);
    man_op(1'b1, 1'b0, 4'h5, 4'h2);
    man_op(1'b1, 1'b1, 4'h5, 4'h7);
    man_op(1'b0, 1'b1, 4'h5, 4'h0);

    // A button held for 100 cycles writes exactly once.
    d = 4'($urandom_range(15));
    d2 = ~d;
    addr_i = 4'h9;
    data_i = d;
    repeat (3) clk_step();
    wren_i = 1'b1;
    repeat (5) clk_step();
    data_i = d2;
    repeat (95) clk_step();
    wren_i = 1'b0;
    mem_m[9] = d;
    repeat (3) clk_step();
    man_op(1'b0, 1'b1, 4'h9, 4'h0);

    for (int i = 0; i < 24; i++) begin
      a = 4'($urandom_range(15));
      d = 4'($urandom_range(15));
      kind = int'($urandom_range(2));
      man_op(kind != 1, kind != 0, a, d);
    end

    for (int i = 0; i < 16; i++) man_op(1'b1, 1'b0, 4'(i), 4'($urandom_range(15)));
    addr_i = 4'h4;
    data_i = ~mem_m[4];
    scan_check(17, 2);
    man_op(1'b0, 1'b1, 4'h4, 4'h0);

    // Reset with a non-zero display, then reset again in the middle of the clear.
    man_op(1'b1, 1'b0, 4'h1, 4'hC);
    man_op(1'b0, 1'b1, 4'h1, 4'h0);
    tick_chk_en = 0;
    rst_i = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk_in);
    #1;
    rst_i = 1'b1;
    cyc = 0;
    tick_chk_en = 1;
    repeat (7) clk_step();
    chk("mid_clear_busy", 32'(busy0), 32'h1);
    tick_chk_en = 0;
    rst_i = 1'b0;
    #1;
    check_reset_outputs("mid_clear_reset");
    repeat (2) @(posedge clk_in);
    #1;
    release_and_count_busy("clear2", 1'b0);
    scan_check(16, -10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
